// File: rtl/frame_multi_buffer.sv
// frame_multi_buffer
//
// Single-clock N-bank frame store with double (BUFFER_COUNT=2) or triple (BUFFER_COUNT=3)
// buffering. The capture side writes into the write buffer while the scan side reads from a
// separate read buffer. Swap/consume events rotate buffer roles so the two never collide.
//
// Optional feature: define FRAME_MULTI_BUFFER_BYTE_MASK_EN to add the per-block write
// enable input wr_be. Without it every write updates the whole bank word.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   wr_en          per-bank write strobe
//   wr_addr        per-bank write address, bank b at [b*AW +: AW]
//   wr_data        per-bank write data, bank b at [b*BW +: BW]
//   wr_be          (optional) per-block write enable, bank b block k at [b*BLOCK_COUNT+k]
//   swap_req       pulse: writer finished a frame
//   rd_next        pulse: reader starts a new frame (triple mode only)
//   rd_en          read strobe common to all banks
//   rd_addr        per-bank read address
//   rd_data_flat   read data, bank b at [b*BW +: BW], two cycles after rd_en
//   rd_valid       rd_data_flat valid (rd_en delayed by two cycles)
//   data_valid     at least one frame published since reset
//   frame_dropped  pulse: an unread published frame was discarded

module frame_multi_buffer #(
    parameter int unsigned ADDRESS_DEPTH    = 256,
    parameter int unsigned BANK_COUNT       = 2,
    parameter int unsigned BLOCK_COUNT      = 1,
    parameter int unsigned BLOCK_DATA_WIDTH = 8,
    parameter int unsigned BUFFER_COUNT     = 2,
    localparam int unsigned AW = $clog2(ADDRESS_DEPTH),
    localparam int unsigned BW = BLOCK_COUNT * BLOCK_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BANK_COUNT-1:0]      wr_en,
    input  logic [BANK_COUNT*AW-1:0]   wr_addr,
    input  logic [BANK_COUNT*BW-1:0]   wr_data,
`ifdef FRAME_MULTI_BUFFER_BYTE_MASK_EN
    input  logic [BANK_COUNT*BLOCK_COUNT-1:0] wr_be,
`endif
    input  logic                       swap_req,
    input  logic                       rd_next,
    input  logic                       rd_en,
    input  logic [BANK_COUNT*AW-1:0]   rd_addr,
    output logic [BANK_COUNT*BW-1:0]   rd_data_flat,
    output logic                       rd_valid,
    output logic                       data_valid,
    output logic                       frame_dropped
);

    // Select width: one bit addresses two buffers, two bits address three.
    localparam int unsigned SW        = (BUFFER_COUNT == 3) ? 2 : 1;
    localparam int unsigned MEM_DEPTH = BUFFER_COUNT * ADDRESS_DEPTH;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if ((BUFFER_COUNT != 2) && (BUFFER_COUNT != 3)) begin : g_bad_buffer_count
        $error("frame_multi_buffer: BUFFER_COUNT must be 2 or 3");
    end

    if ((32'd1 << AW) != ADDRESS_DEPTH) begin : g_bad_depth
        $error("frame_multi_buffer: ADDRESS_DEPTH must be a power of 2");
    end

    // ------------------------------------------------------------------
    // Role registers
    // ------------------------------------------------------------------
    logic [SW-1:0] wr_sel_q, wr_sel_d;
    logic [SW-1:0] rd_sel_q, rd_sel_d;
    logic          drop_d, drop_q;
    logic          data_valid_d, data_valid_q;

    if (BUFFER_COUNT == 3) begin : g_triple
        // rdy_sel holds the most recently published frame; fresh marks it unread.
        logic [SW-1:0] rdy_sel_q, rdy_sel_d;
        logic          fresh_q, fresh_d;

        always_comb begin
            wr_sel_d  = wr_sel_q;
            rd_sel_d  = rd_sel_q;
            rdy_sel_d = rdy_sel_q;
            fresh_d   = fresh_q;
            drop_d    = 1'b0;
            if (swap_req && rd_next) begin
                // Reader takes the just-finished frame directly; any pending ready frame
                // is overwritten.
                rd_sel_d  = wr_sel_q;
                wr_sel_d  = rdy_sel_q;
                rdy_sel_d = rd_sel_q;
                fresh_d   = 1'b0;
                drop_d    = fresh_q;
            end else if (swap_req) begin
                rdy_sel_d = wr_sel_q;
                wr_sel_d  = rdy_sel_q;
                fresh_d   = 1'b1;
                drop_d    = fresh_q;
            end else if (rd_next && fresh_q) begin
                rd_sel_d  = rdy_sel_q;
                rdy_sel_d = rd_sel_q;
                fresh_d   = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rdy_sel_q <= SW'(2);
                fresh_q   <= 1'b0;
            end else begin
                rdy_sel_q <= rdy_sel_d;
                fresh_q   <= fresh_d;
            end
        end
    end else begin : g_double
        // rd_next has no meaning with only two buffers.
        logic unused_rd_next;
        assign unused_rd_next = rd_next;

        always_comb begin
            wr_sel_d = wr_sel_q;
            rd_sel_d = rd_sel_q;
            drop_d   = 1'b0;
            if (swap_req) begin
                wr_sel_d = rd_sel_q;
                rd_sel_d = wr_sel_q;
            end
        end
    end

    assign data_valid_d = data_valid_q | swap_req;

    // ------------------------------------------------------------------
    // Per-bank storage and first read stage
    // ------------------------------------------------------------------
    logic [BANK_COUNT*BW-1:0] ram_out_flat;

    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        logic [BW-1:0] mem [MEM_DEPTH];
        logic [BW-1:0] ram_q;
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        logic [BW-1:0] wd;

        assign wa = wr_addr[b*AW +: AW];
        assign ra = rd_addr[b*AW +: AW];
        assign wd = wr_data[b*BW +: BW];

        // Writes use wr_sel before any same-cycle swap takes effect.
        always_ff @(posedge clk) begin
            if (wr_en[b]) begin
`ifdef FRAME_MULTI_BUFFER_BYTE_MASK_EN
                for (int k = 0; k < BLOCK_COUNT; k++) begin
                    if (wr_be[b*BLOCK_COUNT + k]) begin
                        mem[{wr_sel_q, wa}][k*BLOCK_DATA_WIDTH +: BLOCK_DATA_WIDTH] <=
                            wd[k*BLOCK_DATA_WIDTH +: BLOCK_DATA_WIDTH];
                    end
                end
`else
                mem[{wr_sel_q, wa}] <= wd;
`endif
            end
        end

        // rd_sel is sampled in the rd_en cycle, so a read coincident with a swap still
        // returns the old buffer.
        always_ff @(posedge clk) begin
            if (rd_en) begin
                ram_q <= mem[{rd_sel_q, ra}];
            end
        end

        assign ram_out_flat[b*BW +: BW] = ram_q;
    end

    // ------------------------------------------------------------------
    // Second read stage and status outputs
    // ------------------------------------------------------------------
    logic                     rd_vld1_d, rd_vld1_q;
    logic                     rd_valid_d, rd_valid_q;
    logic [BANK_COUNT*BW-1:0] rd_data_d, rd_data_q;

    always_comb begin
        rd_vld1_d  = rd_en;
        rd_valid_d = rd_vld1_q;
        rd_data_d  = rd_data_q;
        if (rd_vld1_q) begin
            rd_data_d = ram_out_flat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel_q     <= SW'(0);
            rd_sel_q     <= SW'(1);
            drop_q       <= 1'b0;
            data_valid_q <= 1'b0;
            rd_vld1_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            drop_q       <= drop_d;
            data_valid_q <= data_valid_d;
            rd_vld1_q    <= rd_vld1_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign rd_data_flat  = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign data_valid    = data_valid_q;
    assign frame_dropped = drop_q;

endmodule

// File: tb/tb_frame_multi_buffer.sv
// tb_frame_multi_buffer
//
// Directed bench for frame_multi_buffer. Two instances share one clock:
//   dut_d: double buffering, one bank, 8-bit words, depth 16
//   dut_t: triple buffering, two banks, two 8-bit blocks per word, depth 16
// Define FRAME_MULTI_BUFFER_BYTE_MASK_EN to exercise the per-block write enable.

module tb_frame_multi_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- double-mode instance ----------------
    logic       d_rst, d_swap, d_next, d_rd_en;
    logic [0:0] d_wr_en;
    logic [3:0] d_wr_addr, d_rd_addr;
    logic [7:0] d_wr_data, d_rd_data;
    logic       d_rd_valid, d_data_valid, d_drop;
`ifdef FRAME_MULTI_BUFFER_BYTE_MASK_EN
    logic [0:0] d_wr_be;
`endif

    frame_multi_buffer #(
        .ADDRESS_DEPTH    (16),
        .BANK_COUNT       (1),
        .BLOCK_COUNT      (1),
        .BLOCK_DATA_WIDTH (8),
        .BUFFER_COUNT     (2)
    ) dut_d (
        .clk           (clk),
        .rst           (d_rst),
        .wr_en         (d_wr_en),
        .wr_addr       (d_wr_addr),
        .wr_data       (d_wr_data),
`ifdef FRAME_MULTI_BUFFER_BYTE_MASK_EN
        .wr_be         (d_wr_be),
`endif
        .swap_req      (d_swap),
        .rd_next       (d_next),
        .rd_en         (d_rd_en),
        .rd_addr       (d_rd_addr),
        .rd_data_flat  (d_rd_data),
        .rd_valid      (d_rd_valid),
        .data_valid    (d_data_valid),
        .frame_dropped (d_drop)
    );

    // ---------------- triple-mode instance ----------------
    logic        t_rst, t_swap, t_next, t_rd_en;
    logic [1:0]  t_wr_en;
    logic [7:0]  t_wr_addr, t_rd_addr;
    logic [31:0] t_wr_data, t_rd_data;
    logic        t_rd_valid, t_data_valid, t_drop;
    logic [3:0]  t_wr_be;

    frame_multi_buffer #(
        .ADDRESS_DEPTH    (16),
        .BANK_COUNT       (2),
        .BLOCK_COUNT      (2),
        .BLOCK_DATA_WIDTH (8),
        .BUFFER_COUNT     (3)
    ) dut_t (
        .clk           (clk),
        .rst           (t_rst),
        .wr_en         (t_wr_en),
        .wr_addr       (t_wr_addr),
        .wr_data       (t_wr_data),
`ifdef FRAME_MULTI_BUFFER_BYTE_MASK_EN
        .wr_be         (t_wr_be),
`endif
        .swap_req      (t_swap),
        .rd_next       (t_next),
        .rd_en         (t_rd_en),
        .rd_addr       (t_rd_addr),
        .rd_data_flat  (t_rd_data),
        .rd_valid      (t_rd_valid),
        .data_valid    (t_data_valid),
        .frame_dropped (t_drop)
    );

    // ---------------- helpers ----------------
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_write(input logic [3:0] a, input logic [7:0] d);
        d_wr_en   = 1'b1;
        d_wr_addr = a;
        d_wr_data = d;
        tick();
        d_wr_en   = 1'b0;
    endtask

    task automatic d_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
        d_rd_en   = 1'b1;
        d_rd_addr = a;
        tick();
        d_rd_en   = 1'b0;
        check_val({tag, "_vld1"}, 64'(d_rd_valid), 64'd0);
        tick();
        check_val({tag, "_vld2"}, 64'(d_rd_valid), 64'd1);
        check_val({tag, "_data"}, 64'(d_rd_data), 64'(exp));
    endtask

    task automatic t_write(input logic [3:0] a0, input logic [15:0] d0, input logic [3:0] a1,
                           input logic [15:0] d1, input logic [3:0] be);
        t_wr_en   = 2'b11;
        t_wr_addr = {a1, a0};
        t_wr_data = {d1, d0};
        t_wr_be   = be;
        tick();
        t_wr_en   = 2'b00;
    endtask

    task automatic t_read(input logic [3:0] a0, input logic [3:0] a1, input logic [31:0] exp,
                          input string tag);
        t_rd_en   = 1'b1;
        t_rd_addr = {a1, a0};
        tick();
        t_rd_en   = 1'b0;
        check_val({tag, "_vld1"}, 64'(t_rd_valid), 64'd0);
        tick();
        check_val({tag, "_vld2"}, 64'(t_rd_valid), 64'd1);
        check_val({tag, "_data"}, 64'(t_rd_data), 64'(exp));
    endtask

    // Pulse swap_req and/or rd_next for one cycle; frame_dropped is checked after that edge.
    task automatic t_event(input logic sw, input logic nx, input logic exp_drop,
                           input string tag);
        t_swap = sw;
        t_next = nx;
        tick();
        t_swap = 1'b0;
        t_next = 1'b0;
        check_val({tag, "_drop"}, 64'(t_drop), 64'(exp_drop));
    endtask

    task automatic t_sels(input int w, input int r, input int y, input string tag);
        check_val({tag, "_wr"},  64'(dut_t.wr_sel_q), 64'(w));
        check_val({tag, "_rd"},  64'(dut_t.rd_sel_q), 64'(r));
        check_val({tag, "_rdy"}, 64'(dut_t.g_triple.rdy_sel_q), 64'(y));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        d_rst = 1'b1; d_swap = 1'b0; d_next = 1'b0; d_rd_en = 1'b0;
        d_wr_en = '0; d_wr_addr = '0; d_wr_data = '0; d_rd_addr = '0;
`ifdef FRAME_MULTI_BUFFER_BYTE_MASK_EN
        d_wr_be = 1'b1;
`endif
        t_rst = 1'b1; t_swap = 1'b0; t_next = 1'b0; t_rd_en = 1'b0;
        t_wr_en = '0; t_wr_addr = '0; t_wr_data = '0; t_rd_addr = '0; t_wr_be = 4'hF;

        tick();
        tick();
        d_rst = 1'b0;
        t_rst = 1'b0;

        // Reset state
        check_val("d_rst_valid", 64'(d_rd_valid), 64'd0);
        check_val("d_rst_data",  64'(d_rd_data), 64'd0);
        check_val("d_rst_dv",    64'(d_data_valid), 64'd0);
        check_val("d_rst_drop",  64'(d_drop), 64'd0);
        check_val("t_rst_data",  64'(t_rd_data), 64'd0);
        check_val("t_rst_dv",    64'(t_data_valid), 64'd0);
        t_sels(0, 1, 2, "t_rst");

        // ===== Double mode: basic frame =====
        for (int i = 0; i < 4; i++) d_write(4'(i), 8'hA0 + 8'(i));
        check_val("d_dv_pre_swap", 64'(d_data_valid), 64'd0);
        d_swap = 1'b1;
        tick();
        d_swap = 1'b0;
        check_val("d_dv_post_swap", 64'(d_data_valid), 64'd1);
        for (int i = 0; i < 4; i++) d_read(4'(i), 8'hA0 + 8'(i), $sformatf("d_rd%0d", i));
        tick();
        check_val("d_hold_vld",  64'(d_rd_valid), 64'd0);
        check_val("d_hold_data", 64'(d_rd_data), 64'hA3);

        // ===== Double mode: read/write during swap =====
        // Now wr=buf1, rd=buf0. Put 0x55 in buf1, publish it, then 0xAA into buf0.
        d_write(4'd0, 8'h55);
        d_swap = 1'b1;
        tick();
        d_swap = 1'b0;
        d_write(4'd0, 8'hAA);
        // Read, swap and write all in one cycle.
        d_rd_en   = 1'b1; d_rd_addr = 4'd0;
        d_swap    = 1'b1;
        d_wr_en   = 1'b1; d_wr_addr = 4'd1; d_wr_data = 8'h77;
        tick();
        d_rd_en = 1'b0; d_swap = 1'b0; d_wr_en = 1'b0;
        tick();
        check_val("d_sim_vld",  64'(d_rd_valid), 64'd1);
        check_val("d_sim_old",  64'(d_rd_data), 64'h55);
        d_read(4'd0, 8'hAA, "d_sim_new");
        d_read(4'd1, 8'h77, "d_sim_wr");
        // rd_next is ignored in double mode.
        d_next = 1'b1;
        tick();
        d_next = 1'b0;
        check_val("d_next_drop", 64'(d_drop), 64'd0);
        d_read(4'd0, 8'hAA, "d_next_same");

        // ===== Triple mode: publish then consume =====
        t_write(4'd0, 16'h0011, 4'd5, 16'h1011, 4'hF);
        t_event(1'b1, 1'b0, 1'b0, "t_pub1");
        check_val("t_dv", 64'(t_data_valid), 64'd1);
        t_sels(2, 1, 0, "t_pub1");
        t_event(1'b0, 1'b1, 1'b0, "t_cons1");
        t_sels(2, 0, 1, "t_cons1");
        t_read(4'd0, 4'd5, 32'h1011_0011, "t_f1");
        t_event(1'b0, 1'b1, 1'b0, "t_repeat");
        t_read(4'd0, 4'd5, 32'h1011_0011, "t_f1_rep");

        // ===== Triple mode: dropped frame =====
        t_write(4'd0, 16'h00AA, 4'd5, 16'h10AA, 4'hF);
        t_event(1'b1, 1'b0, 1'b0, "t_swapA");
        t_write(4'd0, 16'h0022, 4'd5, 16'h1022, 4'hF);
        t_event(1'b1, 1'b0, 1'b1, "t_swapB");
        tick();
        check_val("t_drop_pulse_end", 64'(t_drop), 64'd0);
        t_event(1'b0, 1'b1, 1'b0, "t_cons2");
        t_read(4'd0, 4'd5, 32'h1022_0022, "t_f2");

        // ===== Triple mode: swap and consume together =====
        // Roles now wr=2, rd=1, rdy=0, fresh=0.
        t_write(4'd0, 16'h0055, 4'd5, 16'h1055, 4'hF);
        t_event(1'b1, 1'b1, 1'b0, "t_both");
        t_sels(0, 2, 1, "t_both");
        t_read(4'd0, 4'd5, 32'h1055_0055, "t_f3");

        // ===== Partial-word writes =====
        t_write(4'd7, 16'h1234, 4'd7, 16'h5678, 4'hF);
        t_write(4'd7, 16'hBEEF, 4'd7, 16'hCAFE, 4'b1001);
        t_event(1'b1, 1'b0, 1'b0, "t_be_pub");
        t_event(1'b0, 1'b1, 1'b0, "t_be_cons");
`ifdef FRAME_MULTI_BUFFER_BYTE_MASK_EN
        t_read(4'd7, 4'd7, 32'hCA78_12EF, "t_be");
`else
        t_read(4'd7, 4'd7, 32'hCAFE_BEEF, "t_full");
`endif

        // ===== Reset mid-read =====
        t_rd_en   = 1'b1;
        t_rd_addr = {4'd5, 4'd0};
        tick();
        t_rd_en = 1'b0;
        t_rst   = 1'b1;
        tick();
        t_rst   = 1'b0;
        check_val("t_mrst_vld",  64'(t_rd_valid), 64'd0);
        check_val("t_mrst_data", 64'(t_rd_data), 64'd0);
        check_val("t_mrst_dv",   64'(t_data_valid), 64'd0);
        t_sels(0, 1, 2, "t_mrst");
        tick();
        check_val("t_mrst_vld2", 64'(t_rd_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
